spi_byte_slave: RTL and testbench



---
 rtl/spi_byte_slave.sv | 185 ++++++++++++++++++
 tb/tb_spi_byte_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: SPI mode-0 slave front end.
// Synchronizes sclk/mosi/cs_n into clk, deserializes MSB-first bytes into
// single-cycle rx_valid pulses and serializes a response byte onto miso.
// Optional feature macro: SPI_BYTE_TX_EN (TX shift register and miso drive).
// With SPI_BYTE_TX_EN undefined, miso is tied low and tx_byte is ignored.
module spi_byte_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs_n,
   output logic       miso,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_first,
   output logic       frame_err,
   output logic       cs_active,
   input  logic [7:0] tx_byte
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   // Synchronizer chains; bit SYNC_STAGES-1 is the synchronized value.
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q, cs_prev_d;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   // Only 7 bits are kept: the 8th bit goes straight into rx_byte.
   logic [6:0] rx_shift_q, rx_shift_d;
   logic       first_q, first_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_first_q, rx_first_d;
   logic       frame_err_q, frame_err_d;
   logic       frame_live;

   // Shift each pin into its synchronizer and keep one extra stage for edges.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;

   // Synchronizer registers; cs_n chain resets to deselected to avoid a false cs_fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_sync_q   <= cs_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
      end
   end

   // Frame FSM and RX deserializer: next state, bit counter and byte delivery.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      first_d     = first_q;
      rx_byte_d   = rx_byte_q;
      rx_valid_d  = 1'b0;
      rx_first_d  = rx_first_q;
      frame_err_d = 1'b0;
      // A cs_fall coinciding with sclk_rise counts that edge as bit 1.
      frame_live  = (state_q == ACTIVE) || cs_fall;

      if ((state_q == IDLE) && cs_fall) begin
         state_d   = ACTIVE;
         first_d   = 1'b1;
         bit_cnt_d = 3'd0;
      end

      if (frame_live && sclk_rise) begin
         rx_shift_d = {rx_shift_q[5:0], mosi_s};
         bit_cnt_d  = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            rx_byte_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            rx_first_d = first_q;
            first_d    = 1'b0;
         end
      end

      // Evaluated after the rise so a byte completing on this cycle is not an error.
      if ((state_q == ACTIVE) && cs_rise) begin
         frame_err_d = (bit_cnt_d != 3'd0);
         bit_cnt_d   = 3'd0;
         rx_shift_d  = '0;
         state_d     = IDLE;
      end
   end

   // FSM and RX state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= '0;
         first_q     <= 1'b0;
         rx_byte_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_first_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         first_q     <= first_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_first_q  <= rx_first_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_byte   = rx_byte_q;
   assign rx_valid  = rx_valid_q;
   assign rx_first  = rx_first_q;
   assign frame_err = frame_err_q;
   assign cs_active = ~cs_s;

`ifdef SPI_BYTE_TX_EN
   // miso is the MSB of this register, so clearing it deselects the line.
   logic [7:0] tx_shift_q, tx_shift_d;

   // TX serializer: load at frame start, reload at byte boundaries, else shift.
   always_comb begin
      tx_shift_d = tx_shift_q;
      if ((state_q == IDLE) && cs_fall) begin
         tx_shift_d = tx_byte;
      end else if (state_q == ACTIVE) begin
         if (cs_rise) begin
            tx_shift_d = 8'h00;
         end else if (sclk_fall) begin
            if (bit_cnt_q == 3'd0) begin
               tx_shift_d = tx_byte;
            end else begin
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
      end
   end

   // TX shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_q <= 8'h00;
      end else begin
         tx_shift_q <= tx_shift_d;
      end
   end

   assign miso = tx_shift_q[7];
`else
   logic tx_byte_unused;
   assign tx_byte_unused = ^tx_byte;
   assign miso           = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_slave.sv
// tb_spi_byte_slave: table-driven and randomized checks for spi_byte_slave.
// Expected TX behaviour follows SPI_BYTE_TX_EN the same way as the design.
`timescale 1ns/1ps
module tb_spi_byte_slave;

`ifdef SPI_BYTE_TX_EN
   localparam bit TX_EN = 1'b1;
`else
   localparam bit TX_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_n = 1'b1;
   logic       miso;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_first;
   logic       frame_err;
   logic       cs_active;
   logic [7:0] tx_byte = 8'h00;

   int checks = 0;
   int failures = 0;

   // Pulses captured by the monitor
   logic [7:0] got_b[$];
   logic       got_f[$];
   int         ferr_cnt = 0;

   spi_byte_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .miso(miso), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_first(rx_first),
      .frame_err(frame_err), .cs_active(cs_active), .tx_byte(tx_byte)
   );

   always #5 clk = ~clk;

   // Sample pulses on the inactive edge.
   always @(negedge clk) begin
      if (rx_valid) begin
         got_b.push_back(rx_byte);
         got_f.push_back(rx_first);
      end
      if (frame_err) ferr_cnt++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Drive one frame. Bit i of the frame is data[31-i]; tx holds up to four
   // response bytes, left aligned. mode 0 normal, 1 cs_n rises together with
   // the last sclk rise, 2 cs_n falls together with the first sclk rise.
   task automatic do_frame(input int nbits, input logic [31:0] data,
                           input logic [31:0] tx, input int mode);
      logic [7:0] txv;
      logic       exp_m;
      got_b.delete();
      got_f.delete();
      ferr_cnt = 0;
      tx_byte = tx[31:24];
      if (mode != 2) begin
         cs_n = 1'b0;
         #50;
         check("cs_active", {31'd0, cs_active}, 32'd1);
      end
      for (int i = 0; i < nbits; i++) begin
         mosi = data[31-i];
         #50;
         if (!(mode == 2 && i == 0)) begin
            txv   = tx[31-8*(i/8) -: 8];
            exp_m = TX_EN ? txv[7-(i%8)] : 1'b0;
            check($sformatf("miso bit%0d", i), {31'd0, miso}, {31'd0, exp_m});
         end
         if (mode == 2 && i == 0) cs_n = 1'b0;
         if (mode == 1 && i == nbits - 1) cs_n = 1'b1;
         sclk = 1'b1;
         #40;
         if ((i % 8 == 7) && (i / 8 < 3)) tx_byte = tx[23-8*(i/8) -: 8];
         #10;
         sclk = 1'b0;
      end
      #50;
      cs_n = 1'b1;
      #100;
   endtask

   // Compare captured pulses against expectations for a frame.
   task automatic check_frame(input string tag, input int exp_n, input int exp_err,
                              input logic [31:0] exp_data);
      int n;
      check({tag, " rx_valid count"}, got_b.size(), exp_n);
      check({tag, " frame_err count"}, ferr_cnt, exp_err);
      n = (got_b.size() < exp_n) ? got_b.size() : exp_n;
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s byte%0d", tag, k), {24'd0, got_b[k]}, {24'd0, exp_data[31-8*k -: 8]});
         check($sformatf("%s first%0d", tag, k), {31'd0, got_f[k]}, (k == 0) ? 32'd1 : 32'd0);
      end
      $display("frame %s: bytes=%0d frame_err=%0d", tag, got_b.size(), ferr_cnt);
   endtask

   typedef struct {
      int          nbits;
      logic [31:0] data;
      logic [31:0] tx;
      int          mode;
      int          exp_n;
      int          exp_err;
      logic [31:0] exp_bytes;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int nb;
      logic [31:0] rd, rt;

      vecs[0] = '{8,  32'h1000_0000, 32'h3C00_0000, 0, 1, 0, 32'h1000_0000};
      vecs[1] = '{24, 32'h1001_0000, 32'h3CC3_5A00, 0, 3, 0, 32'h1001_0000};
      vecs[2] = '{5,  32'hFF00_0000, 32'h0000_0000, 0, 0, 1, 32'h0000_0000};
      vecs[3] = '{8,  32'hA500_0000, 32'h9600_0000, 0, 1, 0, 32'hA500_0000};
      vecs[4] = '{16, 32'h1234_0000, 32'h3CC3_0000, 0, 2, 0, 32'h1234_0000};
      vecs[5] = '{8,  32'h8100_0000, 32'hF000_0000, 1, 1, 0, 32'h8100_0000};
      vecs[6] = '{8,  32'h4200_0000, 32'hAA00_0000, 2, 1, 0, 32'h4200_0000};

      // Reset state
      @(negedge clk);
      #2;
      #100;
      @(negedge clk);
      check("reset miso", {31'd0, miso}, 32'd0);
      check("reset rx_byte", {24'd0, rx_byte}, 32'd0);
      check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset rx_first", {31'd0, rx_first}, 32'd0);
      check("reset frame_err", {31'd0, frame_err}, 32'd0);
      check("reset cs_active", {31'd0, cs_active}, 32'd0);
      #2;
      rst_n = 1'b1;
      #50;

      // sclk activity while deselected is ignored
      got_b.delete();
      got_f.delete();
      ferr_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         mosi = i[0];
         #50 sclk = 1'b1;
         #50 sclk = 1'b0;
      end
      #100;
      check("idle rx_valid count", got_b.size(), 0);
      check("idle frame_err count", ferr_cnt, 0);
      check("idle cs_active", {31'd0, cs_active}, 32'd0);

      // Directed vectors
      for (int v = 0; v < 7; v++) begin
         do_frame(vecs[v].nbits, vecs[v].data, vecs[v].tx, vecs[v].mode);
         check_frame($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_err, vecs[v].exp_bytes);
      end
      check("idle miso", {31'd0, miso}, 32'd0);

      // Reset in the middle of a byte
      got_b.delete();
      got_f.delete();
      ferr_cnt = 0;
      cs_n = 1'b0;
      #50;
      for (int i = 0; i < 4; i++) begin
         mosi = 1'b1;
         #50 sclk = 1'b1;
         #50 sclk = 1'b0;
      end
      #20;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst miso", {31'd0, miso}, 32'd0);
      check("midrst rx_byte", {24'd0, rx_byte}, 32'd0);
      check("midrst rx_first", {31'd0, rx_first}, 32'd0);
      check("midrst cs_active", {31'd0, cs_active}, 32'd0);
      #3;
      cs_n = 1'b1;
      #50;
      rst_n = 1'b1;
      #100;
      check("midrst rx_valid count", got_b.size(), 0);
      check("midrst frame_err count", ferr_cnt, 0);
      do_frame(8, 32'h5A00_0000, 32'h6900_0000, 0);
      check_frame("after_reset", 1, 0, 32'h5A00_0000);

      // Randomized frames against the reference model: full bytes are
      // delivered MSB-first, a trailing partial byte raises frame_err once.
      for (int r = 0; r < 8; r++) begin
         nb = $urandom_range(1, 32);
         rd = $urandom;
         rt = $urandom;
         do_frame(nb, rd, rt, 0);
         check_frame($sformatf("rand%0d_n%0d", r, nb), nb / 8, (nb % 8 != 0) ? 1 : 0, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
